// File: rtl/test_sweep_pkg.sv
// Shared types and helpers for the exhaustive vector sweep controller.
package test_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  // Highest vector index of an n-bit exhaustive sweep.
  function automatic int last_vec(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/test_sweep_ctrl_settle_cnt.sv
// Clearable settle-time up-counter; tc flags the last APPLY cycle of a vector.
module settle_cnt #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The count reaches SETTLE-1 on the SETTLE-th APPLY cycle.
  assign tc = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/test_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives vectors, waits SETTLE cycles, compares
// the block under test with the golden model and records the first mismatch.
module test_sweep_ctrl
  import test_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] res_in,
  input  logic [N_OUT-1:0] exp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int FC_W = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(last_vec(N_IN));

  sweep_state_t state, state_nx;
  logic settle_tc;
  logic init, check_en, step, cnt_en;
  logic mismatch, at_last;

  assign mismatch = (res_in != exp_in);
  assign at_last  = (vec_out == LAST_VEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // abort outranks both start and the completion of a CHECK cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (abort)      state_nx = ST_IDLE;
        else if (start) state_nx = ST_APPLY;
      end
      ST_APPLY: begin
        if (abort)          state_nx = ST_IDLE;
        else if (settle_tc) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)        state_nx = ST_IDLE;
        else if (at_last) state_nx = ST_DONE;
        else              state_nx = ST_APPLY;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    init     = 1'b0;
    check_en = 1'b0;
    step     = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: init = start && !abort;
      ST_APPLY:         cnt_en = !abort;
      ST_CHECK: begin
        check_en = !abort;
        step     = !abort && !at_last;
      end
      default: ;
    endcase
  end

  settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk (clk),
    .rst (rst),
    .clr (init || step),
    .en  (cnt_en),
    .tc  (settle_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      busy <= (state_nx == ST_APPLY) || (state_nx == ST_CHECK);
      done <= (state_nx == ST_DONE);
      if (init) begin
        vec_out          <= '0;
        pass             <= 1'b0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
      end else if (check_en) begin
        if (step) vec_out <= vec_out + N_IN'(1);
        if (mismatch) begin
          fail_count <= fail_count + FC_W'(1);
          if (!first_fail_valid) begin
            first_fail_vec   <= vec_out;
            first_fail_valid <= 1'b1;
          end
        end
        // pass must reflect the final vector's comparison as well.
        if (at_last) pass <= (fail_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_test_sweep_ctrl.sv
// Bench for test_sweep_ctrl: SETTLE=1 and SETTLE=3 instances against a
// timeline model of the sweep plus hand-computed expectations.
module tb_test_sweep_ctrl;

  localparam int LASTV = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [1:0] lut   [8];
  logic [1:0] fault [8];

  logic [2:0] vec1, vec3, ffv1, ffv3;
  logic [1:0] res1, exp1, res3, exp3;
  logic       busy1, done1, pass1, ffval1;
  logic       busy3, done3, pass3, ffval3;
  logic [3:0] fc1, fc3;
  logic [2:0] d1 = '0, d2 = '0;

  int checks = 0;
  int errors = 0;

  int m_act [2], m_t [2], m_vec [2], m_done [2], m_pass [2];
  int m_fc [2], m_ffv [2], m_ffval [2];

  always #5 clk = ~clk;

  // The SETTLE=3 block under test answers two cycles late.
  always @(posedge clk) begin
    d1 <= vec3;
    d2 <= d1;
  end

  assign exp1 = lut[vec1];
  assign res1 = lut[vec1] ^ fault[vec1];
  assign exp3 = lut[vec3];
  assign res3 = lut[d2] ^ fault[d2];

  test_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .vec_out(vec1), .res_in(res1), .exp_in(exp1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  test_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .vec_out(vec3), .res_in(res3), .exp_in(exp3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3),
    .first_fail_vec(ffv3), .first_fail_valid(ffval3)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_vec[i] = 0; m_done[i] = 0; m_pass[i] = 0;
      m_fc[i] = 0; m_ffv[i] = 0; m_ffval[i] = 0;
    end
  endtask

  // A sweep is a timeline: cycle t of it works on vector t/(S+1), and the
  // last cycle of each vector's slot is where the comparison happens.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int s;
      int v;
      s = (i == 0) ? 1 : 3;
      if (m_act[i] == 0) begin
        if (abort) m_done[i] = 0;
        else if (start) begin
          m_act[i] = 1; m_t[i] = 0; m_vec[i] = 0; m_fc[i] = 0;
          m_ffval[i] = 0; m_done[i] = 0;
        end
      end else if (abort) begin
        m_act[i] = 0;
      end else begin
        v = m_t[i] / (s + 1);
        if (m_t[i] % (s + 1) == s) begin
          if (fault[v] != 2'b00) begin
            m_fc[i]++;
            if (m_ffval[i] == 0) begin
              m_ffv[i] = v;
              m_ffval[i] = 1;
            end
          end
          if (v == LASTV) begin
            m_act[i] = 0; m_done[i] = 1; m_pass[i] = (m_fc[i] == 0) ? 1 : 0;
          end
        end
        m_t[i]++;
        if (m_act[i] != 0) m_vec[i] = m_t[i] / (s + 1);
      end
    end
  endtask

  task automatic compare_inst(input int i, input logic [2:0] vec, input logic b,
                              input logic d, input logic p, input logic [3:0] fc,
                              input logic [2:0] ffv, input logic ffval);
    chk($sformatf("vec_out[s%0d]", i), vec, m_vec[i]);
    chk($sformatf("busy[s%0d]", i), b, m_act[i]);
    chk($sformatf("done[s%0d]", i), d, m_done[i]);
    chk($sformatf("fail_count[s%0d]", i), fc, m_fc[i]);
    chk($sformatf("first_fail_valid[s%0d]", i), ffval, m_ffval[i]);
    chk($sformatf("first_fail_vec[s%0d]", i), ffv, m_ffv[i]);
    if (m_done[i] != 0) chk($sformatf("pass[s%0d]", i), p, m_pass[i]);
  endtask

  task automatic compare_all();
    compare_inst(0, vec1, busy1, done1, pass1, fc1, ffv1, ffval1);
    compare_inst(1, vec3, busy3, done3, pass3, fc3, ffv3, ffval3);
  endtask

  // Inputs change at the falling edge; outputs are checked one edge later.
  task automatic step(input logic st, input logic ab);
    start = st;
    abort = ab;
    model_update();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    compare_all();
  endtask

  task automatic wait_both_done(input string name);
    int n;
    n = 0;
    while (!(done1 && done3) && n < 100) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (!(done1 && done3)) chk({name, "_timeout"}, n, -1);
  endtask

  task automatic wait_vec1(input int v, input string name);
    int n;
    n = 0;
    while (vec1 != 3'(v) && n < 40) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (vec1 != 3'(v)) chk({name, "_timeout"}, vec1, v);
  endtask

  task automatic check_reset_literals(input string name);
    chk({name, "_vec"}, {vec3, vec1}, 0);
    chk({name, "_busy"}, {busy3, busy1}, 0);
    chk({name, "_done"}, {done3, done1}, 0);
    chk({name, "_pass"}, {pass3, pass1}, 0);
    chk({name, "_fc"}, {fc3, fc1}, 0);
    chk({name, "_ffv"}, {ffv3, ffv1}, 0);
    chk({name, "_ffval"}, {ffval3, ffval1}, 0);
  endtask

  initial begin
    int n, n3;
    for (int v = 0; v < 8; v++) begin
      lut[v]   = 2'($urandom_range(0, 3));
      fault[v] = 2'b00;
    end
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_literals("reset");
    rst = 1'b0;
    compare_all();

    // Clean sweep: 16 cycles at SETTLE=1, 32 cycles at SETTLE=3.
    step(1'b1, 1'b0);
    chk("busy_after_start", busy1, 1);
    n = 0;
    while (!done1 && n < 40) begin step(1'b0, 1'b0); n++; end
    n3 = n;
    while (!done3 && n3 < 80) begin step(1'b0, 1'b0); n3++; end
    chk("sweep_len_s1", n, 16);
    chk("sweep_len_s3", n3, 32);
    chk("clean_pass", {pass3, pass1}, 2'b11);
    chk("clean_fc", fc1, 0);
    chk("clean_ffval", ffval1, 0);

    // Restart from DONE with a start re-pulse mid-sweep that must be ignored.
    step(1'b1, 1'b0);
    n = 0;
    while (!done1 && n < 40) begin step(n == 5, 1'b0); n++; end
    chk("restart_len_s1", n, 16);
    wait_both_done("restart");

    // Faults on vectors 3 and 6.
    fault[3] = 2'b01;
    fault[6] = 2'b10;
    step(1'b1, 1'b0);
    wait_both_done("fault36");
    chk("fault36_fc", fc1, 2);
    chk("fault36_ffv", ffv1, 3);
    chk("fault36_pass", pass1, 0);
    chk("fault36_fc_s3", fc3, 2);

    // Every vector mismatches.
    for (int v = 0; v < 8; v++) fault[v] = 2'b11;
    step(1'b1, 1'b0);
    wait_both_done("allfail");
    chk("allfail_fc", fc1, 8);
    chk("allfail_ffv", ffv1, 0);
    chk("allfail_fc_s3", fc3, 8);

    // Abort at vector 4 keeps the partial count (vector 3 already failed).
    for (int v = 0; v < 8; v++) fault[v] = 2'b00;
    fault[3] = 2'b01;
    step(1'b1, 1'b0);
    wait_vec1(4, "abort");
    step(1'b0, 1'b1);
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_fc", fc1, 1);

    // Asynchronous reset at vector 5 clears outputs before any clock edge.
    step(1'b1, 1'b0);
    wait_vec1(5, "rst");
    #2 rst = 1'b1;
    #1 check_reset_literals("async_rst");
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    compare_all();

    // Randomised traffic: table and fault changes, stray starts and aborts.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int v = 0; v < 8; v++) begin
          lut[v]   = 2'($urandom_range(0, 3));
          fault[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_sweep_ctrl.md
# test_sweep_ctrl

Hardware sequencer that exhaustively sweeps every input vector of a small combinational block under test and checks its outputs against a golden model. It drives the DUT inputs, waits a programmable settle time, then compares DUT outputs with expected values. It accumulates pass/fail status and reports the first failing vector. It is the synthesizable counterpart of our exhaustive `{A,B,C}` sweep and sits between a golden-model block and the circuit under test.

## Interface

Parameters:
- `N_IN`, default 3: DUT input width; the sweep covers vectors 0 .. 2^N_IN-1.
- `N_OUT`, default 2: DUT output width.
- `SETTLE`, default 1 (≥1): cycles each vector is held before sampling.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE or DONE.
- `abort` in 1: cancel a sweep in progress.
- `vec_out` out N_IN: vector driven to the DUT inputs (MSB = A).
- `res_in` in N_OUT: DUT outputs.
- `exp_in` in N_OUT: golden-model outputs for the current `vec_out`.
- `busy` out 1: high in APPLY/CHECK.
- `done` out 1: high in DONE; held until the next start or abort.
- `pass` out 1: valid when `done`=1; high iff zero mismatches.
- `fail_count` out N_IN+1: number of mismatching vectors.
- `first_fail_vec` out N_IN: first mismatching vector.
- `first_fail_valid` out 1: `first_fail_vec` holds a real mismatch.

## Operation

- States: IDLE, APPLY, CHECK, DONE.
- IDLE → APPLY on `start`. On that edge: `vec_out`←0, settle counter←0, `fail_count`←0, `first_fail_valid`←0, `done`←0.
- APPLY: hold `vec_out`. The counter increments each cycle. After SETTLE cycles in APPLY, go to CHECK.
- CHECK (one cycle): compare `res_in` with `exp_in`.
  - On mismatch: `fail_count`+1. If `first_fail_valid`=0, capture `first_fail_vec`←`vec_out` and set `first_fail_valid`.
  - If `vec_out` = 2^N_IN-1, go to DONE and leave `vec_out` unchanged (no wrap to 0).
  - Otherwise `vec_out`+1 and return to APPLY with the counter cleared.
- DONE: `done`=1, `pass`=(`fail_count`==0). `start` → APPLY, with the same initialisation as from IDLE.
- `start` in APPLY/CHECK is ignored.
- `abort` in APPLY/CHECK → IDLE next edge. `done` stays 0; `fail_count` and `first_fail_*` keep their partial values. `abort` has priority over a CHECK-cycle completion. In IDLE/DONE, `abort` → IDLE and clears `done`.
- `fail_count` width N_IN+1 holds the all-fail value 2^N_IN without overflow.

## Timing

- Reset values: state IDLE, `vec_out`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_vec`=0, `first_fail_valid`=0.
- All outputs are registered. `pass` is a registered copy, updated on entry to DONE.
- The `start` edge puts `busy`=1 on the next cycle.
- Each vector takes SETTLE+1 cycles. A full sweep takes 2^N_IN·(SETTLE+1) cycles from the first APPLY cycle until `done` rises.
- `res_in` and `exp_in` are sampled on the clock edge that ends the CHECK cycle. Both must be combinational functions of `vec_out`, stable after SETTLE cycles.
- `rst` asserted mid-sweep forces reset values immediately (asynchronous). The sweep does not resume.

## Structure

- Shared package `test_sweep_pkg`: state enum (IDLE/APPLY/CHECK/DONE) and the 2^N_IN last-vector constant function.
- One natural sub-module: `settle_cnt`, a clearable up-counter with a terminal-count flag at SETTLE. The FSM, vector register and fail accounting stay in `test_sweep_ctrl`.

## Test plan

- Golden model = DUT, N_IN=3, SETTLE=1, `start` pulse → `vec_out` steps 0..7, one step every 2 cycles; `done`=1 after 16 cycles, `pass`=1, `fail_count`=0, `first_fail_valid`=0.
- Fault injected at vectors 3 and 6 → `fail_count`=2, `first_fail_vec`=3, `pass`=0.
- All vectors mismatch → `fail_count`=8 (no overflow), `first_fail_vec`=0.
- `start` re-pulsed mid-sweep → ignored, total still 16 cycles. `start` again in DONE → counters cleared, a second identical sweep runs.
- `abort` at `vec_out`=4 → IDLE next cycle, `done`=0, `busy`=0. Separately, `rst` pulsed at `vec_out`=5 → all outputs at reset values within the same cycle.
- SETTLE=3 → each vector held 4 cycles, `done` after 32 cycles; a DUT delaying outputs 2 cycles still gives `pass`=1.
